alu_arbiter: RTL and testbench

//  Shares the single combinational alu_module among NUM_REQ requesters, e.g. the integer pipe and the fuzzy unit.

---
 rtl/alu_ctrl_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/alu_arbiter.sv | 163 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU arbiter: control word width, opcode boundaries,
// arbiter state encoding and opcode classification helpers.
package alu_ctrl_pkg;

    localparam int ALU_CTRL_W = 5;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD      = 5'd0;
    localparam logic [ALU_CTRL_W-1:0] ALU_MUL      = 5'd2;
    localparam logic [ALU_CTRL_W-1:0] ALU_MUL_ALT  = 5'd15;
    localparam logic [ALU_CTRL_W-1:0] ALU_CMP_LO   = 5'd18;
    localparam logic [ALU_CTRL_W-1:0] ALU_CMP_HI   = 5'd22;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT2     = 5'd28;
    localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_MAX = ALU_SLT2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    function automatic logic is_cmp(input logic [ALU_CTRL_W-1:0] ctrl);
        return (ctrl >= ALU_CMP_LO) && (ctrl <= ALU_CMP_HI);
    endfunction

    function automatic logic is_mul(input logic [ALU_CTRL_W-1:0] ctrl);
        return (ctrl == ALU_MUL) || (ctrl == ALU_MUL_ALT);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly after
// ptr, searching cyclically, and reports the winner as one-hot and as an index.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest candidate inwards so the nearest one after ptr wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters: round-robin issue,
// registered ALU operands, per-op settle time and a held valid/ready response.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int MUL_LAT = 3,
    parameter int ID_W    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [ALU_CTRL_W*NUM_REQ-1:0] req_ctrl,
    input  logic [32*NUM_REQ-1:0]         req_a,
    input  logic [32*NUM_REQ-1:0]         req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [31:0]                   rsp_res,
    output logic                          rsp_zero,
    output logic                          rsp_err,
    output logic [31:0]                   alu_num1,
    output logic [31:0]                   alu_num2,
    output logic [ALU_CTRL_W-1:0]         alu_ctrl,
    input  logic [31:0]                   alu_res,
    input  logic                          alu_zero
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        id_q, id_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [31:0]             alu_num1_q, alu_num1_d;
    logic [31:0]             alu_num2_q, alu_num2_d;
    logic [ALU_CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [31:0]             rsp_res_q, rsp_res_d;
    logic                    rsp_zero_q, rsp_zero_d;
    logic                    rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0]      grant;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_valid;
    logic [ALU_CTRL_W-1:0]   sel_ctrl;

    logic [ALU_CTRL_W-1:0]   ctrl_arr [NUM_REQ];
    logic [31:0]             a_arr    [NUM_REQ];
    logic [31:0]             b_arr    [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign ctrl_arr[g] = req_ctrl[g*ALU_CTRL_W +: ALU_CTRL_W];
        assign a_arr[g]    = req_a[g*32 +: 32];
        assign b_arr[g]    = req_b[g*32 +: 32];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req         (req_valid),
        .ptr         (rr_ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        alu_num1_d  = alu_num1_q;
        alu_num2_d  = alu_num2_q;
        alu_ctrl_d  = alu_ctrl_q;
        rsp_valid_d = rsp_valid_q;
        rsp_res_d   = rsp_res_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = '0;
        sel_ctrl    = ctrl_arr[grant_idx];

        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    req_ready  = grant;
                    alu_ctrl_d = sel_ctrl;
                    alu_num1_d = a_arr[grant_idx];
                    alu_num2_d = b_arr[grant_idx];
                    id_d       = grant_idx;
                    rr_ptr_d   = grant_idx;
                    cnt_d      = is_mul(sel_ctrl) ? CNT_W'(MUL_LAT - 1) : '0;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Compare ops report only the flag; everything else only the value.
                    rsp_valid_d = 1'b1;
                    rsp_res_d   = is_cmp(alu_ctrl_q) ? 32'd0 : alu_res;
                    rsp_zero_d  = is_cmp(alu_ctrl_q) ? alu_zero : 1'b0;
                    rsp_err_d   = (alu_ctrl_q > ALU_CTRL_MAX);
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Accept is combinational, so keep it quiet while reset is asserted.
        if (!rst_n) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            id_q        <= '0;
            cnt_q       <= '0;
            alu_num1_q  <= '0;
            alu_num2_q  <= '0;
            alu_ctrl_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            alu_num1_q  <= alu_num1_d;
            alu_num2_q  <= alu_num2_d;
            alu_ctrl_q  <= alu_ctrl_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign alu_num1  = alu_num1_q;
    assign alu_num2  = alu_num2_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = ID_W'(id_q);
    assign rsp_res   = rsp_res_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a stand-in ALU plus a transaction-level model of
// arbitration order, latency and response contents.
module tb_alu_arbiter;

    localparam int NUM_REQ = 2;
    localparam int MUL_LAT = 3;
    localparam int ID_W    = 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [5*NUM_REQ-1:0]  req_ctrl = '0;
    logic [32*NUM_REQ-1:0] req_a = '0;
    logic [32*NUM_REQ-1:0] req_b = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_res;
    logic                  rsp_zero;
    logic                  rsp_err;
    logic [31:0]           alu_num1;
    logic [31:0]           alu_num2;
    logic [4:0]            alu_ctrl;
    logic [31:0]           alu_res;
    logic                  alu_zero;

    int total = 0;
    int bad = 0;
    int model_last = NUM_REQ - 1;

    always #5 clk = ~clk;

    alu_arbiter #(
        .NUM_REQ (NUM_REQ),
        .MUL_LAT (MUL_LAT),
        .ID_W    (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ctrl  (req_ctrl),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err),
        .alu_num1  (alu_num1),
        .alu_num2  (alu_num2),
        .alu_ctrl  (alu_ctrl),
        .alu_res   (alu_res),
        .alu_zero  (alu_zero)
    );

    // Stand-in ALU: compare ops return a never-zero junk value so masking is visible.
    function automatic logic [32:0] alu_fn(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic z;
        r = a ^ {b[15:0], b[31:16]} ^ {27'd0, c};
        z = 1'b0;
        case (c)
            5'd0:        r = a + b;
            5'd1:        r = a - b;
            5'd2, 5'd15: r = a * b;
            default:     ;
        endcase
        z = (r == 32'd0);
        if (c >= 5'd18 && c <= 5'd22) begin
            r = (a + b) | 32'h1;
            case (c)
                5'd18:   z = (a == b);
                5'd19:   z = ($signed(a) >= $signed(b));
                5'd20:   z = (a != b);
                5'd21:   z = (a >= b);
                default: z = (a < b);
            endcase
        end
        return {z, r};
    endfunction

    assign {alu_zero, alu_res} = alu_fn(alu_ctrl, alu_num1, alu_num2);

    // Expected {err, zero, res} of a completed operation.
    function automatic logic [33:0] exp_rsp(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] f;
        f = alu_fn(c, a, b);
        if (c >= 5'd18 && c <= 5'd22) return {1'b0, f[32], 32'd0};
        return {(c > 5'd28), 1'b0, f[31:0]};
    endfunction

    function automatic int next_winner(input logic [NUM_REQ-1:0] mask, input int last);
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (mask[(last + i) % NUM_REQ]) return (last + i) % NUM_REQ;
        end
        return -1;
    endfunction

    // Issues one request from a single requester and collects the response.
    task automatic run_op(input int who, input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                          output int wg, output int lat, output logic [ID_W-1:0] id,
                          output logic [31:0] res, output logic zero, output logic err,
                          output logic [4:0] ex_ctrl, output logic [31:0] ex_a, output bit tmo);
        tmo = 1'b0; wg = 0; lat = 0; id = '0; res = '0; zero = 1'b0; err = 1'b0;
        ex_ctrl = '0; ex_a = '0;
        req_ctrl[who*5 +: 5] = c;
        req_a[who*32 +: 32]  = a;
        req_b[who*32 +: 32]  = b;
        req_valid[who]       = 1'b1;
        #1;
        while (!req_ready[who] && wg < 20) begin
            @(negedge clk); #1; wg++;
        end
        if (!req_ready[who]) begin
            tmo = 1'b1; req_valid[who] = 1'b0; return;
        end
        model_last = who;
        @(negedge clk);
        req_valid[who] = 1'b0;
        #1;
        lat = 1; ex_ctrl = alu_ctrl; ex_a = alu_num1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        if (!rsp_valid) begin
            tmo = 1'b1; return;
        end
        id = rsp_id; res = rsp_res; zero = rsp_zero; err = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '1;
        #3;
        total++; if (req_ready !== '0) begin bad++; $display("[TB] FAIL reset_req_ready got=%0b exp=0", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
        total++; if ({rsp_res, rsp_zero, rsp_err, rsp_id} !== '0) begin bad++; $display("[TB] FAIL reset_rsp got=%0h exp=0", {rsp_res, rsp_zero, rsp_err, rsp_id}); end
        total++; if ({alu_num1, alu_num2, alu_ctrl} !== '0) begin bad++; $display("[TB] FAIL reset_alu_regs got=%0h exp=0", {alu_num1, alu_num2, alu_ctrl}); end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_last = NUM_REQ - 1;
        #1;
    endtask

    task automatic test_single_add();
        int wg, lat; logic [ID_W-1:0] id; logic [31:0] res, ex_a; logic zero, err; logic [4:0] ex_c; bit tmo;
        run_op(0, 5'd0, 32'd5, 32'd7, wg, lat, id, res, zero, err, ex_c, ex_a, tmo);
        total++; if (tmo) begin bad++; $display("[TB] FAIL add_timeout got=1 exp=0"); end
        total++; if (wg !== 0) begin bad++; $display("[TB] FAIL add_grant_wait got=%0d exp=0", wg); end
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL add_latency got=%0d exp=2", lat); end
        total++; if (id !== ID_W'(0)) begin bad++; $display("[TB] FAIL add_id got=%0d exp=0", id); end
        total++; if (res !== 32'd12) begin bad++; $display("[TB] FAIL add_res got=%0h exp=c", res); end
        total++; if (zero !== 1'b0 || err !== 1'b0) begin bad++; $display("[TB] FAIL add_flags got=%0b%0b exp=00", zero, err); end
        total++; if (ex_c !== 5'd0 || ex_a !== 32'd5) begin bad++; $display("[TB] FAIL add_alu_regs got=%0h/%0h exp=0/5", ex_c, ex_a); end
    endtask

    task automatic test_multiply();
        int wg, lat; logic [ID_W-1:0] id; logic [31:0] res, ex_a; logic zero, err; logic [4:0] ex_c; bit tmo;
        run_op(1, 5'd2, -32'sd3, 32'd4, wg, lat, id, res, zero, err, ex_c, ex_a, tmo);
        total++; if (tmo) begin bad++; $display("[TB] FAIL mul_timeout got=1 exp=0"); end
        total++; if (lat !== 1 + MUL_LAT) begin bad++; $display("[TB] FAIL mul_latency got=%0d exp=%0d", lat, 1 + MUL_LAT); end
        total++; if (id !== ID_W'(1)) begin bad++; $display("[TB] FAIL mul_id got=%0d exp=1", id); end
        total++; if (res !== 32'hFFFF_FFF4) begin bad++; $display("[TB] FAIL mul_res got=%0h exp=fffffff4", res); end
        total++; if (ex_c !== 5'd2 || ex_a !== 32'hFFFF_FFFD) begin bad++; $display("[TB] FAIL mul_alu_regs got=%0h/%0h exp=2/fffffffd", ex_c, ex_a); end
    endtask

    task automatic test_contention();
        logic [31:0] ca [NUM_REQ];
        logic [31:0] cb [NUM_REQ];
        int exp_id[$];
        logic [31:0] exp_res[$];
        int grants = 0, nresp = 0, last_cyc = -1, pending = -1, w;
        for (int i = 0; i < NUM_REQ; i++) begin
            ca[i] = $urandom; cb[i] = $urandom;
            req_ctrl[i*5 +: 5] = 5'd1; req_a[i*32 +: 32] = ca[i]; req_b[i*32 +: 32] = cb[i];
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        #1;
        for (int cyc = 0; cyc < 80 && nresp < 4; cyc++) begin
            if (req_ready != '0) begin
                w = next_winner(req_valid, model_last);
                total++; if (req_ready !== (NUM_REQ'(1) << w)) begin bad++; $display("[TB] FAIL contention_grant got=%0b exp_idx=%0d", req_ready, w); end
                if (last_cyc >= 0) begin
                    total++; if (cyc - last_cyc != 3) begin bad++; $display("[TB] FAIL contention_spacing got=%0d exp=3", cyc - last_cyc); end
                end
                last_cyc = cyc;
                exp_id.push_back(w);
                exp_res.push_back(ca[w] - cb[w]);
                model_last = w; pending = w; grants++;
            end
            if (rsp_valid) begin
                if (exp_id.size() == 0) begin
                    total++; bad++; $display("[TB] FAIL contention_unexpected_rsp got=1 exp=0");
                end else begin
                    total++; if (rsp_id !== ID_W'(exp_id[0])) begin bad++; $display("[TB] FAIL contention_id got=%0d exp=%0d", rsp_id, exp_id[0]); end
                    total++; if (rsp_res !== exp_res[0]) begin bad++; $display("[TB] FAIL contention_res got=%0h exp=%0h", rsp_res, exp_res[0]); end
                    void'(exp_id.pop_front());
                    void'(exp_res.pop_front());
                end
                nresp++;
            end
            @(negedge clk);
            if (pending >= 0) begin
                ca[pending] = $urandom; cb[pending] = $urandom;
                req_a[pending*32 +: 32] = ca[pending]; req_b[pending*32 +: 32] = cb[pending];
                pending = -1;
            end
            if (grants >= 4) req_valid = '0;
            #1;
        end
        total++; if (nresp != 4) begin bad++; $display("[TB] FAIL contention_count got=%0d exp=4", nresp); end
        req_valid = '0;
        rsp_ready = 1'b0;
        while (rsp_valid) begin
            rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0; #1;
        end
    endtask

    task automatic test_compare();
        int wg, lat; logic [ID_W-1:0] id; logic [31:0] res, ex_a, a, b; logic zero, err; logic [4:0] ex_c, c; bit tmo;
        logic [33:0] e;
        run_op(0, 5'd18, 32'd9, 32'd9, wg, lat, id, res, zero, err, ex_c, ex_a, tmo);
        total++; if (tmo || zero !== 1'b1 || res !== 32'd0) begin bad++; $display("[TB] FAIL cmp_eq got=z%0b/r%0h exp=z1/r0", zero, res); end
        run_op(1, 5'd19, 32'hFFFF_FFFF, 32'd0, wg, lat, id, res, zero, err, ex_c, ex_a, tmo);
        total++; if (tmo || zero !== 1'b0 || res !== 32'd0) begin bad++; $display("[TB] FAIL cmp_signed got=z%0b/r%0h exp=z0/r0", zero, res); end
        for (int i = 0; i < 4; i++) begin
            c = 5'($urandom_range(18, 22));
            a = $urandom_range(0, 3); b = $urandom_range(0, 3);
            e = exp_rsp(c, a, b);
            run_op(i % NUM_REQ, c, a, b, wg, lat, id, res, zero, err, ex_c, ex_a, tmo);
            total++; if (tmo || {err, zero, res} !== e) begin bad++; $display("[TB] FAIL cmp_rand got=%0h exp=%0h ctrl=%0d", {err, zero, res}, e, c); end
        end
    endtask

    task automatic test_error();
        int wg, lat; logic [ID_W-1:0] id; logic [31:0] res, ex_a, a, b; logic zero, err; logic [4:0] ex_c; bit tmo;
        a = $urandom; b = $urandom;
        run_op(0, 5'd30, a, b, wg, lat, id, res, zero, err, ex_c, ex_a, tmo);
        total++; if (tmo || err !== 1'b1) begin bad++; $display("[TB] FAIL err_flag got=%0b exp=1", err); end
        total++; if (res !== alu_fn(5'd30, a, b)) begin bad++; $display("[TB] FAIL err_res got=%0h exp=%0h", res, alu_fn(5'd30, a, b)); end
        run_op(1, 5'd28, a, b, wg, lat, id, res, zero, err, ex_c, ex_a, tmo);
        total++; if (tmo || err !== 1'b0) begin bad++; $display("[TB] FAIL err_boundary28 got=%0b exp=0", err); end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, x, y;
        int k;
        a = $urandom; b = $urandom; x = $urandom; y = $urandom;
        req_ctrl[0 +: 5] = 5'd0; req_a[0 +: 32] = a; req_b[0 +: 32] = b;
        req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL bp_grant0 got=%0b exp=01", req_ready); end
        @(negedge clk);
        req_valid = 2'b10;
        req_ctrl[5 +: 5] = 5'd1; req_a[32 +: 32] = x; req_b[32 +: 32] = y;
        #1;
        k = 0;
        while (!rsp_valid && k < 20) begin
            total++; if (req_ready !== '0) begin bad++; $display("[TB] FAIL bp_exec_ready got=%0b exp=0", req_ready); end
            @(negedge clk); #1; k++;
        end
        for (int i = 0; i < 5; i++) begin
            total++; if (rsp_valid !== 1'b1 || rsp_res !== a + b || rsp_id !== ID_W'(0)) begin bad++; $display("[TB] FAIL bp_hold got=v%0b/%0h/%0d exp=v1/%0h/0", rsp_valid, rsp_res, rsp_id, a + b); end
            total++; if (req_ready !== '0) begin bad++; $display("[TB] FAIL bp_ready_low got=%0b exp=0", req_ready); end
            @(negedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release got=%0b exp=0", rsp_valid); end
        total++; if (req_ready !== 2'b10) begin bad++; $display("[TB] FAIL bp_next_grant got=%0b exp=10", req_ready); end
        model_last = 1;
        @(negedge clk);
        req_valid = '0;
        #1;
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(negedge clk); #1; k++;
        end
        total++; if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(1) || rsp_res !== x - y) begin bad++; $display("[TB] FAIL bp_second_rsp got=v%0b/%0d/%0h exp=v1/1/%0h", rsp_valid, rsp_id, rsp_res, x - y); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
    endtask

    task automatic test_random();
        int wg, lat, who, elat; logic [ID_W-1:0] id; logic [31:0] res, ex_a, a, b; logic zero, err; logic [4:0] ex_c, c; bit tmo;
        logic [33:0] e;
        for (int i = 0; i < 10; i++) begin
            who = $urandom_range(0, NUM_REQ - 1);
            c = 5'($urandom_range(0, 31));
            a = $urandom; b = $urandom;
            e = exp_rsp(c, a, b);
            elat = (c == 5'd2 || c == 5'd15) ? 1 + MUL_LAT : 2;
            run_op(who, c, a, b, wg, lat, id, res, zero, err, ex_c, ex_a, tmo);
            total++; if (tmo || {err, zero, res} !== e) begin bad++; $display("[TB] FAIL rand_rsp got=%0h exp=%0h ctrl=%0d", {err, zero, res}, e, c); end
            total++; if (lat !== elat || id !== ID_W'(who)) begin bad++; $display("[TB] FAIL rand_lat_id got=%0d/%0d exp=%0d/%0d", lat, id, elat, who); end
        end
    endtask

    task automatic test_reset_mid_exec();
        int k;
        req_ctrl[0 +: 5] = 5'd2; req_a[0 +: 32] = 32'd6; req_b[0 +: 32] = 32'd7;
        req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL rst_mid_grant got=%0b exp=01", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #3;
        req_ctrl[0 +: 5] = 5'd0; req_a[0 +: 32] = 32'd1; req_b[0 +: 32] = 32'd2;
        req_ctrl[5 +: 5] = 5'd0; req_a[32 +: 32] = 32'd3; req_b[32 +: 32] = 32'd4;
        req_valid = '1;
        rst_n = 1'b0;
        #1;
        total++; if ({alu_ctrl, alu_num1, alu_num2} !== '0) begin bad++; $display("[TB] FAIL rst_mid_alu got=%0h exp=0", {alu_ctrl, alu_num1, alu_num2}); end
        total++; if (rsp_valid !== 1'b0 || req_ready !== '0) begin bad++; $display("[TB] FAIL rst_mid_outputs got=v%0b/r%0b exp=0/0", rsp_valid, req_ready); end
        @(negedge clk); @(negedge clk);
        #1;
        rst_n = 1'b1;
        model_last = NUM_REQ - 1;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL rst_first_grant got=%0b exp=01", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        k = 1;
        while (!rsp_valid && k < 20) begin
            @(negedge clk); #1; k++;
        end
        total++; if (k !== 2 || rsp_id !== ID_W'(0) || rsp_res !== 32'd3) begin bad++; $display("[TB] FAIL rst_post_rsp got=lat%0d/%0d/%0h exp=lat2/0/3", k, rsp_id, rsp_res); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_multiply();
        test_contention();
        test_compare();
        test_error();
        test_backpressure();
        test_random();
        test_reset_mid_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
